// File: rtl/ava_display_out.sv
// rtl/ava_display_out.sv - pixel FIFO and VGA-style timing generator for the AVA display path
// Pixels from VRAM are queued, then presented one per active pixel tick with hsync/vsync/de.

module ava_pixel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module ava_display_out #(
  parameter int PIXEL_WIDTH = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int FULL_MARGIN = 2,
  parameter int START_LEVEL = 8,
  parameter int CLK_DIV     = 4,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit SYNC_POL    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pixel_valid,
  input  logic [PIXEL_WIDTH-1:0] pixel_data,
  output logic                   pixel_fifo_full,
  input  logic                   err_clr,
  output logic [PIXEL_WIDTH-1:0] pix_out,
  output logic                   de,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   frame_start,
  output logic                   underflow,
  output logic                   overflow
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_nxt;
  logic [DW-1:0]          div_cnt;
  logic [HW-1:0]          h_cnt;
  logic [VW-1:0]          v_cnt;
  logic [CW-1:0]          fifo_count;
  logic [PIXEL_WIDTH-1:0] fifo_data;
  logic                   tick, active, fifo_empty, fifo_at_max;
  logic                   push, pop, hs_on, vs_on;

  assign fifo_empty      = (fifo_count == '0);
  assign fifo_at_max     = (fifo_count == CW'(FIFO_DEPTH));
  assign pixel_fifo_full = (fifo_count >= CW'(FIFO_DEPTH - FULL_MARGIN));

  assign tick   = (state == RUN) && (div_cnt == DIV_LAST);
  assign active = tick && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign push   = pixel_valid && !fifo_at_max;
  assign pop    = active && !fifo_empty;
  assign hs_on  = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
  assign vs_on  = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);

  ava_pixel_fifo #(.WIDTH(PIXEL_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (pixel_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Timing stays parked until enough pixels are buffered; only reset returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fifo_count >= CW'(START_LEVEL)) state_nxt = RUN;
      RUN:     state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (state != RUN) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      if (tick) begin
        if (h_cnt == H_LAST_C) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + VW'(1);
        end else begin
          h_cnt <= h_cnt + HW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_out     <= '0;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
      if (tick) begin
        de      <= active;
        hsync   <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync   <= vs_on ? SYNC_POL : ~SYNC_POL;
        pix_out <= pop ? fifo_data : '0;
      end
    end
  end

  // A new error event in the same cycle wins over err_clr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (active && fifo_empty)     underflow <= 1'b1;
      else if (err_clr)             underflow <= 1'b0;
      if (pixel_valid && fifo_at_max) overflow <= 1'b1;
      else if (err_clr)               overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ava_display_out.sv
// tb/tb_ava_display_out.sv - scoreboard bench for ava_display_out on a shrunken raster
// Instance a starts at 8 buffered pixels; instance b starts at 16 for the overflow scenario.

module tb_ava_display_out;
  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int DIV = 4;
  localparam int FRAME_NS = HT * VT * DIV * 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       a_valid = 1'b0, a_err_clr = 1'b0;
  logic [7:0] a_data = '0, a_pix;
  logic       a_full, a_de, a_hsync, a_vsync, a_fs, a_uf, a_of;
  logic       b_valid = 1'b0, b_err_clr = 1'b0;
  logic [7:0] b_data = '0, b_pix;
  logic       b_full, b_de, b_hsync, b_vsync, b_fs, b_uf, b_of;

  ava_display_out #(.START_LEVEL(8), .CLK_DIV(DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_a (
    .clk(clk), .reset(reset), .pixel_valid(a_valid), .pixel_data(a_data),
    .pixel_fifo_full(a_full), .err_clr(a_err_clr), .pix_out(a_pix), .de(a_de),
    .hsync(a_hsync), .vsync(a_vsync), .frame_start(a_fs), .underflow(a_uf), .overflow(a_of));

  ava_display_out #(.START_LEVEL(16), .CLK_DIV(DIV),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)) u_b (
    .clk(clk), .reset(reset), .pixel_valid(b_valid), .pixel_data(b_data),
    .pixel_fifo_full(b_full), .err_clr(b_err_clr), .pix_out(b_pix), .de(b_de),
    .hsync(b_hsync), .vsync(b_vsync), .frame_start(b_fs), .underflow(b_uf), .overflow(b_of));

  int total = 0;
  int bad = 0;
  logic [7:0] sb[$];

  bit  track = 1'b0;
  bit  starved_seen = 1'b0;
  int  phase = 0, samp = 0, line_de = 0;
  time last_fs = 0;

  // Raster model: one new output sample every DIV clocks after the first de.
  task automatic monitor();
    int h, v;
    bit exp_de, exp_hs, exp_vs, exp_fs;
    logic [7:0] exp_px;
    exp_fs = 1'b0;
    if (phase == 0) begin
      h = samp % HT;
      v = (samp / HT) % VT;
      exp_de = (h < HA) && (v < VA);
      exp_hs = !((h >= HA + HF) && (h < HA + HF + HS));
      exp_vs = !((v >= VA + VF) && (v < VA + VF + VS));
      exp_fs = (h == 0) && (v == 0);
      total++;
      if (a_de !== exp_de || a_hsync !== exp_hs || a_vsync !== exp_vs) begin
        bad++;
        $display("FAIL timing s=%0d h=%0d v=%0d got de/hs/vs=%b%b%b want %b%b%b",
                 samp, h, v, a_de, a_hsync, a_vsync, exp_de, exp_hs, exp_vs);
      end
      exp_px = 8'd0;
      if (exp_de) begin
        if (sb.size() > 0) exp_px = sb.pop_front();
        else starved_seen = 1'b1;
      end
      total++;
      if (a_pix !== exp_px) begin
        bad++;
        $display("FAIL pixel s=%0d got %0d want %0d", samp, a_pix, exp_px);
      end
      if (a_de === 1'b1) line_de++;
      if (h == HT - 1) begin
        total++;
        if (line_de != ((v < VA) ? HA : 0)) begin
          bad++;
          $display("FAIL de_per_line v=%0d got %0d want %0d", v, line_de, (v < VA) ? HA : 0);
        end
        line_de = 0;
      end
      if (a_fs === 1'b1) begin
        if (last_fs != 0) begin
          total++;
          if ($time - last_fs != FRAME_NS) begin
            bad++;
            $display("FAIL frame_period got %0t want %0d", $time - last_fs, FRAME_NS);
          end
        end
        last_fs = $time;
      end
      samp++;
    end
    total++;
    if (a_fs !== exp_fs) begin
      bad++;
      $display("FAIL frame_start s=%0d ph=%0d got %b want %b", samp, phase, a_fs, exp_fs);
    end
    phase = (phase + 1) % DIV;
  endtask

  task automatic step_a(input bit want);
    if (want && !a_full) begin
      a_valid = 1'b1;
      a_data  = 8'($urandom);
      sb.push_back(a_data);
    end else begin
      a_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    if (track) monitor();
  endtask

  task automatic test_reset();
    int errs;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({a_pix, a_de, a_hsync, a_vsync, a_fs, a_uf, a_of, a_full} !== {8'd0, 7'b0110000}) begin
      bad++;
      $display("FAIL reset_a got %b", {a_pix, a_de, a_hsync, a_vsync, a_fs, a_uf, a_of, a_full});
    end
    total++;
    if ({b_pix, b_de, b_hsync, b_vsync, b_fs, b_uf, b_of, b_full} !== {8'd0, 7'b0110000}) begin
      bad++;
      $display("FAIL reset_b got %b", {b_pix, b_de, b_hsync, b_vsync, b_fs, b_uf, b_of, b_full});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (a_de !== 1'b0 || a_hsync !== 1'b1 || a_vsync !== 1'b1 || a_full !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL idle_hold got %0d bad cycles want 0", errs);
    end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 17; k++) begin
      b_valid = 1'b1;
      b_data  = 8'(k);
      @(posedge clk);
      @(negedge clk);
      total++;
      if (k <= 16 && (b_full !== (k >= 14) || b_of !== 1'b0)) begin
        bad++;
        $display("FAIL full_level k=%0d got full=%b of=%b want full=%b of=0", k, b_full, b_of, k >= 14);
      end else if (k == 17 && b_of !== 1'b1) begin
        bad++;
        $display("FAIL overflow_set got %b want 1", b_of);
      end
    end
    b_valid = 1'b0;
    b_err_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_err_clr = 1'b0;
    total++;
    if (b_of !== 1'b0) begin
      bad++;
      $display("FAIL overflow_clr got %b want 0", b_of);
    end
  endtask

  task automatic test_first_pixel();
    logic [7:0] exp_px;
    for (int k = 1; k <= 8; k++) begin
      a_valid = 1'b1;
      a_data  = 8'(k);
      sb.push_back(a_data);
      @(posedge clk);
      @(negedge clk);
    end
    a_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i < 5) begin
        total++;
        if (a_de !== 1'b0) begin
          bad++;
          $display("FAIL first_de_early clk=%0d got de=%b want 0", i, a_de);
        end
      end
    end
    exp_px = sb.pop_front();
    total++;
    if (a_de !== 1'b1 || a_pix !== exp_px || a_fs !== 1'b1) begin
      bad++;
      $display("FAIL first_pixel got de=%b pix=%0d fs=%b want 1 %0d 1", a_de, a_pix, a_fs, exp_px);
    end
    last_fs = $time;
    line_de = 1;
    samp    = 1;
    phase   = 1;
    track   = 1'b1;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6000; i++) step_a($urandom_range(0, 3) != 0);
    total++;
    if (a_uf !== 1'b0 || a_of !== 1'b0) begin
      bad++;
      $display("FAIL stream_errors got uf=%b of=%b want 0 0", a_uf, a_of);
    end
  endtask

  task automatic test_underflow();
    bit seen;
    int n;
    starved_seen = 1'b0;
    n = 0;
    while (!starved_seen && n < 3000) begin
      step_a(1'b0);
      n++;
    end
    total++;
    if (!starved_seen || a_uf !== 1'b1 || a_de !== 1'b1 || a_pix !== 8'd0) begin
      bad++;
      $display("FAIL underflow_set got seen=%b uf=%b de=%b pix=%0d want 1 1 1 0",
               starved_seen, a_uf, a_de, a_pix);
    end
    a_err_clr = 1'b1;
    step_a(1'b0);
    a_err_clr = 1'b0;
    total++;
    if (a_uf !== 1'b0) begin
      bad++;
      $display("FAIL underflow_clr got %b want 0", a_uf);
    end
    seen = 1'b0;
    a_err_clr = 1'b1;
    for (int i = 0; i < 200; i++) begin
      step_a(1'b0);
      if (a_uf === 1'b1) seen = 1'b1;
    end
    a_err_clr = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL underflow_priority got never-set want set while err_clr held");
    end
  endtask

  task automatic test_reset_mid();
    int n, errs;
    n = 0;
    while (a_de !== 1'b1 && n < 400) begin
      step_a(1'b0);
      n++;
    end
    total++;
    if (a_de !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_wait got de=%b want 1", a_de);
    end
    track = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({a_pix, a_de, a_hsync, a_vsync, a_fs, a_uf, a_full} !== {8'd0, 6'b011000}) begin
      bad++;
      $display("FAIL reset_async got %b", {a_pix, a_de, a_hsync, a_vsync, a_fs, a_uf, a_full});
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_de !== 1'b0 || a_full !== 1'b0 || a_uf !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL reset_mid_idle got %0d bad cycles want 0", errs);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_first_pixel();
    test_stream();
    test_underflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ava_display_out.md
Name: ava_display_out

Overview:
- Downstream stage of the AVA coordinate/VRAM-address controller.
- Buffers the pixel stream returned by VRAM in a synchronous FIFO and raises the FIFO-full flag the controller stalls on.
- Generates VGA-style display timing (hsync, vsync, data-enable) from a divided pixel tick, and pops one pixel per active tick toward the DAC/pins.
- Single clock domain; the pixel rate is derived by a clock-enable divider.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel (RGB332).
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- FULL_MARGIN, 2, free slots still left when pixel_fifo_full asserts (covers the 1-cycle VRAM latency).
- START_LEVEL, 8, fill level needed before timing leaves IDLE.
- CLK_DIV, 4, system clocks per pixel tick.
- H_ACTIVE/H_FP/H_SYNC/H_BP, 640/16/96/48, horizontal timing in ticks.
- V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical timing in lines.
- SYNC_POL, 0, active level of hsync/vsync.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pixel_valid  in  1  VRAM read data valid this cycle.
- pixel_data  in  PIXEL_WIDTH  pixel from VRAM.
- pixel_fifo_full  out  1  stall request to the controller.
- err_clr  in  1  clears the sticky error flags.
- pix_out  out  PIXEL_WIDTH  displayed pixel; 0 outside the active area.
- de  out  1  active video.
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- frame_start  out  1  one-clock pulse when the first active pixel of a frame is presented.
- underflow  out  1  sticky: pop requested while the FIFO was empty.
- overflow  out  1  sticky: push arrived while the FIFO was full.

Behaviour:
- Reset (async assert, sync-released logic): FIFO empty (count=0), pointers 0, tick divider 0, h_cnt=v_cnt=0, state IDLE. Outputs: pix_out=0, de=0, hsync=vsync=!SYNC_POL, frame_start=0, underflow=overflow=0, pixel_fifo_full=0.
- FIFO push: occurs when pixel_valid=1 and count<FIFO_DEPTH. If count==FIFO_DEPTH, the data is dropped and overflow is set.
- FIFO pop: occurs on an active tick (defined below) when count>0. If count==0, pix_out=0 and underflow is set.
- Simultaneous push and pop leave count unchanged; both pointers advance.
- pixel_fifo_full = (count >= FIFO_DEPTH-FULL_MARGIN). It is combinational from the registered count.
- Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.
- Tick divider: counts 0..CLK_DIV-1 and wraps. tick=1 when the divider equals CLK_DIV-1. The divider is held at 0 in IDLE.
- State machine IDLE -> RUN: transition when count>=START_LEVEL. The first tick in RUN occurs CLK_DIV cycles after the transition, at h_cnt=0, v_cnt=0.
- State machine RUN -> IDLE: only via reset.
- Counters in RUN, on each tick:
  - h_cnt increments and wraps at H_TOTAL-1 (H_TOTAL = sum of the four H parameters).
  - On the h_cnt wrap, v_cnt increments and wraps at V_TOTAL-1.
- Active tick: tick=1 with h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Output registers update only on tick, so all outputs are aligned with a 1-clock latency from the counter state:
  - de = active.
  - hsync = SYNC_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync = SYNC_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
  - pix_out = popped data, or 0 when not active or on underflow.
- frame_start: high for one clk in the cycle after the tick with h_cnt=0 and v_cnt=0.
- err_clr clears underflow and overflow. A set event in the same cycle takes priority over err_clr.
- Reset asserted mid-frame returns every signal to its reset value immediately (asynchronous); stored FIFO data is discarded.

Test Plan:
- Reset then no pushes: state stays IDLE; de=0, hsync=vsync=1, pixel_fifo_full=0 for 1000 clks.
- Push 14 pixels (values 1..14) with no pops (still IDLE, since START_LEVEL is overridden to 16): pixel_fifo_full rises on the cycle count reaches 14; pushes 15 and 16 are accepted; push 17 is dropped and overflow=1.
- Push 8 pixels: the first de pulse appears 5 clks after count reaches 8 (1 transition + 4-clk divider), with pix_out=1 and frame_start=1 on that same cycle.
- Continuous feed, full frame: exactly 640 de ticks per line; hsync low for 96 ticks beginning at tick 656; vsync low for lines 490-491; frame period 800*525*4 clks.
- Starve the feed mid-line: underflow=1 and pix_out=0 while de=1; after err_clr, underflow=0; err_clr held in the same cycle as another empty pop leaves underflow=1.
- Simultaneous push and pop at count=5: count stays 5; data order is preserved (FIFO sequence check over 10k random pushes).
